frame_flow_ctrl: RTL and testbench

- Per-frame sequencer in front of the line-buffer/convolution datapath of the image-processing top.
- Admits exactly one frame of pixels per start command and throttles the input on the output buffer's prog_full.
- After the last real pixel, injects zero pad lines so the 3x3 window flushes the final output rows.
- Pulses frame-done, tracks the current line, and reports busy.

---
 rtl/img_proc_pkg.sv | 22 ++
 rtl/frame_flow_ctrl_pixel_pos_counter.sv | 52 +++++
 rtl/frame_flow_ctrl.sv | 129 ++++++++++++
 tb/tb_frame_flow_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// Shared types and constants for the image-processing front end.
package img_proc_pkg;

  localparam int INTEGER_BITS_DEF     = 8;
  localparam int FIXED_POINT_BITS_DEF = 4;
  localparam int PIXEL_W              = INTEGER_BITS_DEF + FIXED_POINT_BITS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [PIXEL_W-1:0] ZERO_PIXEL = '0;

  // A counter over a single value still needs one bit of storage.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_flow_ctrl_pixel_pos_counter.sv
// Column/line position counter; the line index saturates on the final pixel.
module pixel_pos_counter
  import img_proc_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int LINES  = 514,
  parameter int COL_W  = 9,
  parameter int LINE_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [LINE_W-1:0] line_o,
  output logic              col_last_o,
  output logic              last_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign col_last_o = (col_q == COL_W'(WIDTH - 1));
  assign last_o     = col_last_o && (line_q == LINE_W'(LINES - 1));
  assign line_o     = line_q;

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (clr_i) begin
      col_d  = '0;
      line_d = '0;
    end else if (en_i) begin
      if (col_last_o) begin
        col_d = '0;
        if (!last_o) line_d = line_q + LINE_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/frame_flow_ctrl.sv
// Per-frame pixel admission with prog_full throttling, zero pad-line flush and done pulse.
// Stall statistics are built only when FRAME_CTRL_STATS_EN is defined.
module frame_flow_ctrl
  import img_proc_pkg::*;
#(
  parameter int INTEGER_BITS     = INTEGER_BITS_DEF,
  parameter int FIXED_POINT_BITS = FIXED_POINT_BITS_DEF,
  parameter int IMG_WIDTH        = 512,
  parameter int IMG_HEIGHT       = 512,
  parameter int PAD_LINES        = 2
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_start,
  input  logic                                        i_data_valid,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]    i_data,
  output logic                                        o_data_ready,
  input  logic                                        i_prog_full,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]    o_pixel_data,
  output logic                                        o_pixel_data_valid,
  output logic [safe_clog2(IMG_HEIGHT+PAD_LINES)-1:0] o_line_count,
  output logic                                        o_busy,
  output logic                                        o_frame_done,
  output logic [31:0]                                 o_stall_cycles
);

  localparam int PW     = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int LINES  = IMG_HEIGHT + PAD_LINES;
  localparam int COL_W  = safe_clog2(IMG_WIDTH);
  localparam int LINE_W = safe_clog2(LINES);

  state_e          state_q, state_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            pix_vld_q, pix_vld_d;
  logic            done_q, done_d;

  logic              start_acc, transfer, flush_emit;
  logic [LINE_W-1:0] line_cnt;
  logic              col_last, pos_last, stream_last;

  assign start_acc    = (state_q == ST_IDLE) && i_start;
  assign o_data_ready = (state_q == ST_STREAM) && !i_prog_full;
  assign transfer     = o_data_ready && i_data_valid;
  assign flush_emit   = (state_q == ST_FLUSH) && !i_prog_full;
  assign stream_last  = col_last && (line_cnt == LINE_W'(IMG_HEIGHT - 1));

  pixel_pos_counter #(
    .WIDTH  (IMG_WIDTH),
    .LINES  (LINES),
    .COL_W  (COL_W),
    .LINE_W (LINE_W)
  ) u_pos (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .clr_i      (start_acc),
    .en_i       (transfer || flush_emit),
    .line_o     (line_cnt),
    .col_last_o (col_last),
    .last_o     (pos_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_STREAM;
      ST_STREAM: if (transfer && stream_last) state_d = (PAD_LINES == 0) ? ST_DONE : ST_FLUSH;
      ST_FLUSH:  if (flush_emit && pos_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Real and pad pixels share one output register so latency is identical.
  always_comb begin
    pix_d     = pix_q;
    pix_vld_d = 1'b0;
    if (transfer) begin
      pix_d     = i_data;
      pix_vld_d = 1'b1;
    end else if (flush_emit) begin
      pix_d     = PW'(ZERO_PIXEL);
      pix_vld_d = 1'b1;
    end
  end

  assign done_d = (state_q == ST_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      pix_vld_q <= pix_vld_d;
      done_q    <= done_d;
    end
  end

  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = pix_vld_q;
  assign o_line_count       = line_cnt;
  assign o_busy             = (state_q != ST_IDLE);
  assign o_frame_done       = done_q;

`ifdef FRAME_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc)
      stall_d = '0;
    else if ((state_q == ST_STREAM || state_q == ST_FLUSH) && i_prog_full && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_frame_flow_ctrl.sv
// Self-checking bench for frame_flow_ctrl (4x3 frame, one pad line, plus a no-pad instance).
module tb_frame_flow_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int P  = 1;
  localparam int PW = 12;

`ifdef FRAME_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, start0 = 1'b0;
  logic          valid = 1'b0, pf = 1'b0;
  logic [PW-1:0] din = '0;

  logic          ready, pvalid, busy, done;
  logic [PW-1:0] pdata;
  logic [1:0]    line;
  logic [31:0]   stall;

  logic          ready0, pvalid0, busy0, done0;
  logic [PW-1:0] pdata0;
  logic [1:0]    line0;
  logic [31:0]   stall0;

  always #5 clk = ~clk;

  frame_flow_ctrl #(
    .INTEGER_BITS(8), .FIXED_POINT_BITS(4),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PAD_LINES(P)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data_valid(valid), .i_data(din),
    .o_data_ready(ready), .i_prog_full(pf), .o_pixel_data(pdata),
    .o_pixel_data_valid(pvalid), .o_line_count(line), .o_busy(busy),
    .o_frame_done(done), .o_stall_cycles(stall)
  );

  frame_flow_ctrl #(
    .INTEGER_BITS(8), .FIXED_POINT_BITS(4),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PAD_LINES(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_data_valid(valid), .i_data(din),
    .o_data_ready(ready0), .i_prog_full(pf), .o_pixel_data(pdata0),
    .o_pixel_data_valid(pvalid0), .o_line_count(line0), .o_busy(busy0),
    .o_frame_done(done0), .o_stall_cycles(stall0)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a frame is "active" from start acceptance until its done cycle;
  // the phase follows from how many pixels have been accepted and padded so far.
  bit            m_active;
  int            m_acc, m_z, m_stall;
  bit            m_valid, m_done;
  logic [PW-1:0] m_data;

  function automatic bit m_streaming();
    return m_active && (m_acc < W*H);
  endfunction

  function automatic bit m_flushing();
    return m_active && (m_acc == W*H) && (m_z < P*W);
  endfunction

  function automatic bit m_finished();
    return m_active && (m_acc == W*H) && (m_z == P*W);
  endfunction

  function automatic int m_line();
    int n;
    n = (m_acc + m_z) / W;
    if (n > H + P - 1) n = H + P - 1;
    return n;
  endfunction

  task automatic m_reset();
    m_active = 1'b0; m_acc = 0; m_z = 0; m_stall = 0;
    m_valid = 1'b0; m_done = 1'b0; m_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pix_valid", 32'(pvalid), 32'(m_valid));
    chk("pix_data", 32'(pdata), 32'(m_data));
    chk("frame_done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_active));
    chk("line_count", 32'(line), 32'(m_line()));
    chk("stall_cycles", stall, STATS ? 32'(m_stall) : 32'd0);
  endtask

  // One clock: check last edge's results, drive inputs, check ready, advance the model.
  task automatic cycle(input logic st, input logic v, input logic p, input bit seq);
    @(negedge clk);
    check_outputs();
    start = st; valid = v; pf = p;
    din = seq ? PW'(m_acc + 1) : PW'($urandom);
    #1;
    chk("data_ready", 32'(ready), 32'(m_streaming() && !p));
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (m_streaming()) begin
      if (p) m_stall++;
      else if (v) begin m_valid = 1'b1; m_data = din; m_acc++; end
    end else if (m_flushing()) begin
      if (p) m_stall++;
      else begin m_valid = 1'b1; m_data = '0; m_z++; end
    end else if (m_finished()) begin
      m_done = 1'b1; m_active = 1'b0;
    end else if (st) begin
      m_active = 1'b1; m_acc = 0; m_z = 0; m_stall = 0;
    end
    @(posedge clk);
  endtask

  task automatic stream_until(input int n);
    for (int g = 0; g < 100 && m_acc < n && m_active; g++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic run_to_idle(input int vpct, input int ppct, input bit seq);
    for (int g = 0; g < 300 && m_active; g++)
      cycle(1'b0, ($urandom_range(99) < vpct), ($urandom_range(99) < ppct), seq);
    cycle(1'b0, 1'b0, 1'b0, seq);
    cycle(1'b0, 1'b0, 1'b0, seq);
    chk("frame_timeout_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    check_outputs();
    rst = 1'b0;

    // Basic frame: pixels 1..12 back to back, then 4 zeros and the done pulse.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    run_to_idle(100, 0, 1'b1);

    // Backpressure: 5 stalled cycles in the middle of line 1.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    stream_until(5);
    repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    run_to_idle(100, 0, 1'b1);
    chk("backpressure_stalls", stall, STATS ? 32'd5 : 32'd0);

    // Gapped input: valid alternates every cycle.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 100 && m_active; g++) cycle(1'b0, g[0], 1'b0, 1'b1);
    run_to_idle(100, 0, 1'b1);

    // Start while busy is ignored; a second start afterwards begins a fresh frame.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    stream_until(6);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    run_to_idle(100, 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    run_to_idle(100, 0, 1'b1);

    // Asynchronous reset after pixel 7.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    stream_until(7);
    @(negedge clk);
    check_outputs();
    valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_valid", 32'(pvalid), 32'd0);
    chk("rst_data", 32'(pdata), 32'd0);
    chk("rst_line", 32'(line), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", stall, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    run_to_idle(100, 0, 1'b1);

    // Randomized frames: random data, valid density and prog_full density.
    for (int f = 0; f < 5; f++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      run_to_idle($urandom_range(100, 30), $urandom_range(40, 0), 1'b0);
    end

    // No-pad instance: frame ends straight after pixel 12.
    begin
      int strobes = 0, dones = 0, last_s = -1, done_c = -1, bad = 0, acc0 = 0;
      @(negedge clk);
      start0 = 1'b1; valid = 1'b0; pf = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (pvalid0) begin
          strobes++;
          last_s = c;
          if (pdata0 !== PW'(strobes)) bad++;
        end
        if (done0) begin dones++; done_c = c; end
        start0 = 1'b0; valid = 1'b1;
        din = PW'(acc0 + 1);
        #1;
        if (ready0) acc0++;
      end
      valid = 1'b0;
      chk("pad0_strobes", 32'(strobes), 32'd12);
      chk("pad0_data_order_errors", 32'(bad), 32'd0);
      chk("pad0_done_count", 32'(dones), 32'd1);
      chk("pad0_done_lag", 32'(done_c), 32'(last_s + 1));
      chk("pad0_busy", 32'(busy0), 32'd0);
      chk("pad0_line", 32'(line0), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
